// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arbiter
// Purpose  : Two-port APB4 master. Port 0 is the core LSU and port 1 is a
//            secondary master. The block arbitrates between them, runs the
//            SETUP/ACCESS phases including PREADY wait states, and returns a
//            one-cycle response to the winning port.
// Options  : define APB_TIMEOUT_EN to limit ACCESS-phase wait states to
//            TIMEOUT_CYCLES. On expiry the transfer ends with err=1, rdata=0.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req0_valid,
  input  logic                i_req0_write,
  input  logic [ADDR_W-1:0]   i_req0_addr,
  input  logic [DATA_W-1:0]   i_req0_wdata,
  input  logic [DATA_W/8-1:0] i_req0_strb,
  output logic                o_rsp0_valid,
  output logic [DATA_W-1:0]   o_rsp0_rdata,
  output logic                o_rsp0_err,
  output logic                o_stall0,
  input  logic                i_req1_valid,
  input  logic                i_req1_write,
  input  logic [ADDR_W-1:0]   i_req1_addr,
  input  logic [DATA_W-1:0]   i_req1_wdata,
  input  logic [DATA_W/8-1:0] i_req1_strb,
  output logic                o_rsp1_valid,
  output logic [DATA_W-1:0]   o_rsp1_rdata,
  output logic                o_rsp1_err,
  output logic                o_stall1,
  output logic                o_psel,
  output logic                o_penable,
  output logic                o_pwrite,
  output logic [ADDR_W-1:0]   o_paddr,
  output logic [DATA_W-1:0]   o_pwdata,
  output logic [DATA_W/8-1:0] o_pstrb,
  input  logic [DATA_W-1:0]   i_prdata,
  input  logic                i_pready,
  input  logic                i_pslverr,
  output logic                o_busy,
  output logic                o_owner
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                grant;
  logic                start;
  logic                capture;
  logic                expire;
  logic                owner_q;
  logic                last_grant;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_strb;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] wait_cnt;

  // Count ACCESS wait states of the current transfer; cleared when SETUP is entered.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !i_pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The last permitted wait cycle ends the transfer instead of waiting further.
  assign expire = (state == ACCESS) && !i_pready &&
                  (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // The wait limit has no effect in this build; fold it into a tie-off.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign expire             = 1'b0;
`endif

  // Transfer sequencer state register; reset aborts any transfer in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Arbitration happens in IDLE only, so a grant is never preempted.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (i_req0_valid || i_req1_valid) begin
          start      = 1'b1;
          state_next = SETUP;
          if (i_req0_valid && i_req1_valid) begin
            grant = (PRIO_MODE == 1) ? 1'b0 : ~last_grant;
          end else begin
            grant = i_req1_valid;
          end
        end
      end
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (i_pready) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (expire) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the granted request and capture the completion status.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      owner_q    <= 1'b0;
      last_grant <= 1'b1;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_strb   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (start) begin
        owner_q    <= grant;
        last_grant <= grant;
        lat_write  <= grant ? i_req1_write : i_req0_write;
        lat_addr   <= grant ? i_req1_addr  : i_req0_addr;
        lat_wdata  <= grant ? i_req1_wdata : i_req0_wdata;
        // Reads never drive byte strobes onto the bus.
        if (grant) begin
          lat_strb <= i_req1_write ? i_req1_strb : '0;
        end else begin
          lat_strb <= i_req0_write ? i_req0_strb : '0;
        end
      end
      if (capture) begin
        rdata_q <= lat_write ? '0 : i_prdata;
        err_q   <= i_pslverr;
      end else if (expire) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign o_psel    = (state == SETUP) || (state == ACCESS);
  assign o_penable = (state == ACCESS);
  assign o_pwrite  = lat_write;
  assign o_paddr   = lat_addr;
  assign o_pwdata  = lat_wdata;
  assign o_pstrb   = lat_strb;
  assign o_busy    = (state != IDLE);
  assign o_owner   = owner_q;

  // Response data and error are presented to a port only during its completion pulse.
  assign o_rsp0_valid = (state == DONE) && !owner_q;
  assign o_rsp1_valid = (state == DONE) &&  owner_q;
  assign o_rsp0_rdata = o_rsp0_valid ? rdata_q : '0;
  assign o_rsp1_rdata = o_rsp1_valid ? rdata_q : '0;
  assign o_rsp0_err   = o_rsp0_valid & err_q;
  assign o_rsp1_err   = o_rsp1_valid & err_q;
  assign o_stall0     = i_req0_valid & ~o_rsp0_valid;
  assign o_stall1     = i_req1_valid & ~o_rsp1_valid;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_apb_master_arbiter
// Purpose  : Directed self-checking bench for apb_master_arbiter. A second
//            instance with fixed priority shares the request inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic [3:0]  req0_strb = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic [3:0]  req1_strb = '0;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  logic        rsp0_valid, rsp0_err, stall0, rsp1_valid, rsp1_err, stall1;
  logic [31:0] rsp0_rdata, rsp1_rdata, paddr, pwdata;
  logic        psel, penable, pwrite, busy, owner;
  logic [3:0]  pstrb;

  logic        f_rsp0_valid, f_rsp0_err, f_stall0, f_rsp1_valid, f_rsp1_err, f_stall1;
  logic [31:0] f_rsp0_rdata, f_rsp1_rdata, f_paddr, f_pwdata;
  logic        f_psel, f_penable, f_pwrite, f_busy, f_owner;
  logic [3:0]  f_pstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(req0_valid), .i_req0_write(req0_write), .i_req0_addr(req0_addr),
    .i_req0_wdata(req0_wdata), .i_req0_strb(req0_strb),
    .o_rsp0_valid(rsp0_valid), .o_rsp0_rdata(rsp0_rdata), .o_rsp0_err(rsp0_err), .o_stall0(stall0),
    .i_req1_valid(req1_valid), .i_req1_write(req1_write), .i_req1_addr(req1_addr),
    .i_req1_wdata(req1_wdata), .i_req1_strb(req1_strb),
    .o_rsp1_valid(rsp1_valid), .o_rsp1_rdata(rsp1_rdata), .o_rsp1_err(rsp1_err), .o_stall1(stall1),
    .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr),
    .o_pwdata(pwdata), .o_pstrb(pstrb),
    .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr),
    .o_busy(busy), .o_owner(owner)
  );

  apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1), .TIMEOUT_CYCLES(4)) dut_fixed (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(req0_valid), .i_req0_write(req0_write), .i_req0_addr(req0_addr),
    .i_req0_wdata(req0_wdata), .i_req0_strb(req0_strb),
    .o_rsp0_valid(f_rsp0_valid), .o_rsp0_rdata(f_rsp0_rdata), .o_rsp0_err(f_rsp0_err), .o_stall0(f_stall0),
    .i_req1_valid(req1_valid), .i_req1_write(req1_write), .i_req1_addr(req1_addr),
    .i_req1_wdata(req1_wdata), .i_req1_strb(req1_strb),
    .o_rsp1_valid(f_rsp1_valid), .o_rsp1_rdata(f_rsp1_rdata), .o_rsp1_err(f_rsp1_err), .o_stall1(f_stall1),
    .o_psel(f_psel), .o_penable(f_penable), .o_pwrite(f_pwrite), .o_paddr(f_paddr),
    .o_pwdata(f_pwdata), .o_pstrb(f_pstrb),
    .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr),
    .o_busy(f_busy), .o_owner(f_owner)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with pready raised after 'waits' wait states; report the
  // cycle (relative to the request) of the response pulse, or -1 if none came.
  task automatic run_xfer(input bit port, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int waits, input logic [31:0] rd_in,
                          input logic err_in, output int lat, output logic [31:0] rd,
                          output logic er);
    if (port) begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wd; req1_strb = 4'hF;
    end else begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wd; req0_strb = 4'hF;
    end
    prdata = rd_in; pslverr = err_in;
    lat = -1; rd = '0; er = 1'b0;
    for (int c = 0; c < 40; c++) begin
      pready = (c >= 2 + waits);
      if (port ? rsp1_valid : rsp0_valid) begin
        lat = c;
        rd  = port ? rsp1_rdata : rsp0_rdata;
        er  = port ? rsp1_err : rsp0_err;
        break;
      end
      tick();
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; pready = 1'b0; pslverr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          seq[$];
    int          fseq[$];

    // Reset values
    tick(); tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp0_rdata", rsp0_rdata, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pstrb", pstrb, 0);
    rst = 1'b0;
    tick();

    // Port 0 zero-wait read
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h1000_0004; req0_strb = 4'hF;
    prdata = 32'hDEAD_BEEF; pready = 1'b1;
    #1;
    check("t1_stall0_p0", stall0, 1);
    tick();
    check("t1_psel_p1", psel, 1);
    check("t1_penable_p1", penable, 0);
    check("t1_paddr_p1", paddr, 32'h1000_0004);
    check("t1_pstrb_read", pstrb, 0);
    check("t1_stall0_p1", stall0, 1);
    tick();
    check("t1_penable_p2", penable, 1);
    check("t1_pwrite_p2", pwrite, 0);
    check("t1_stall0_p2", stall0, 1);
    tick();
    check("t1_rsp0_valid", rsp0_valid, 1);
    check("t1_rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
    check("t1_rsp0_err", rsp0_err, 0);
    check("t1_stall0_p3", stall0, 0);
    check("t1_psel_p3", psel, 0);
    check("t1_rsp1_valid", rsp1_valid, 0);
    tick();
    req0_valid = 1'b0; pready = 1'b0;
    check("t1_rsp0_pulse", rsp0_valid, 0);

    // Port 1 write with three wait states
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h2000_0010;
    req1_wdata = 32'hA5A5_0001; req1_strb = 4'hF; prdata = 32'hFFFF_FFFF;
    tick();
    check("t2_owner", owner, 1);
    tick();
    for (int c = 2; c <= 5; c++) begin
      check("t2_penable", penable, 1);
      check("t2_pwdata", pwdata, 32'hA5A5_0001);
      check("t2_paddr", paddr, 32'h2000_0010);
      check("t2_pstrb", pstrb, 4'hF);
      check("t2_pwrite", pwrite, 1);
      check("t2_no_rsp", rsp1_valid, 0);
      if (c == 5) pready = 1'b1;
      tick();
    end
    check("t2_rsp1_valid", rsp1_valid, 1);
    check("t2_rsp1_rdata", rsp1_rdata, 0);
    check("t2_rsp1_err", rsp1_err, 0);
    tick();
    req1_valid = 1'b0; pready = 1'b0;

    // Slave error then a clean transfer
    run_xfer(1'b0, 1'b0, 32'h3000_0008, 32'h0, 0, 32'h1111_2222, 1'b1, lat, rd, er);
    check("t4_lat", lat, 3);
    check("t4_err", er, 1);
    check("t4_rdata", rd, 32'h1111_2222);
    check("t4_err_gone", rsp0_err, 0);
    check("t4_idle", busy, 0);
    run_xfer(1'b0, 1'b0, 32'h3000_000C, 32'h0, 1, 32'h3333_4444, 1'b0, lat, rd, er);
    check("t4b_lat", lat, 4);
    check("t4b_err", er, 0);
    check("t4b_rdata", rd, 32'h3333_4444);

    // Reset during an ACCESS wait
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h4000_0000; pready = 1'b0;
    tick(); tick();
    check("t5_psel_before", psel, 1);
    check("t5_penable_before", penable, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_psel_async", psel, 0);
    check("t5_penable_async", penable, 0);
    check("t5_busy_async", busy, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t5_no_rsp", rsp0_valid, 0);
    end
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("t5_idle_after", busy, 0);

    // Continuous contention; first tie after reset goes to port 0
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h5000_0000;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h6000_0000;
    prdata = 32'h0000_00AA; pready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (rsp0_valid) seq.push_back(0);
      if (rsp1_valid) seq.push_back(1);
      if (f_rsp0_valid) fseq.push_back(0);
      if (f_rsp1_valid) fseq.push_back(1);
      if (i == 1) begin
        check("t3_first_owner", owner, 0);
        check("t3_stall1_other_owns", stall1, 1);
      end
      if (i == 7) check("t3_stall1_rsp", stall1, 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; pready = 1'b0;
    check("t3_rr_count", seq.size(), 4);
    check("t3_fixed_count", fseq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t3_rr_order", (i < seq.size()) ? seq[i] : -1, i % 2);
      check("t3_fixed_order", (i < fseq.size()) ? fseq[i] : -1, 0);
    end
    tick();

`ifdef APB_TIMEOUT_EN
    // Wait limit expiry with pready held low
    run_xfer(1'b0, 1'b0, 32'h7000_0000, 32'h0, 1000, 32'h5555_5555, 1'b0, lat, rd, er);
    check("t6_lat", lat, 6);
    check("t6_err", er, 1);
    check("t6_rdata", rd, 0);
    pready = 1'b1;
    tick();
    pready = 1'b0;
    check("t6_late_pready", rsp0_valid, 0);
    check("t6_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-requester APB4 master that shares the single peripheral APB bus between the core LSU (port 0) and a secondary master such as debug or DMA (port 1).
- Arbitrates between the two ports and sequences the APB SETUP/ACCESS phases, including PREADY wait states.
- Returns read data and error status to the winning port.
- Generates the per-port stall signal the hazard unit uses to freeze the pipeline while an LSU APB transfer is outstanding.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width (multiple of 8).
- PRIO_MODE, 0, arbitration mode: 0 = round-robin; 1 = fixed priority, port 0 always wins.
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req0_valid  in  1  port 0 request; held with its fields stable until o_rsp0_valid.
- i_req0_write  in  1  1 = write, 0 = read.
- i_req0_addr  in  ADDR_W  address.
- i_req0_wdata  in  DATA_W  write data.
- i_req0_strb  in  DATA_W/8  write byte strobes.
- o_rsp0_valid  out  1  one-cycle completion pulse.
- o_rsp0_rdata  out  DATA_W  read data, valid with o_rsp0_valid.
- o_rsp0_err  out  1  PSLVERR or timeout, valid with o_rsp0_valid.
- o_stall0  out  1  i_req0_valid & ~o_rsp0_valid (combinational).
- i_req1_* / o_rsp1_* / o_stall1  as port 0.
- o_psel, o_penable, o_pwrite  out  1  APB control.
- o_paddr  out  ADDR_W  APB address.
- o_pwdata  out  DATA_W  APB write data.
- o_pstrb  out  DATA_W/8  APB byte strobes.
- i_prdata  in  DATA_W  APB read data.
- i_pready  in  1  APB ready.
- i_pslverr  in  1  APB slave error.
- o_busy  out  1  state != IDLE.
- o_owner  out  1  granted port; meaningful only while o_busy.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req_valid is set, grant a port and latch its write/addr/wdata/strb into internal registers, then go to SETUP.
  - If no request, remain in IDLE.
- SETUP: psel=1, penable=0; always advances to ACCESS.
- ACCESS: psel=1, penable=1.
  - i_pready=0: stay in ACCESS (wait state).
  - i_pready=1: register rdata (reads only; writes return 0) and err=i_pslverr, then go to DONE.
- DONE: psel=0; assert o_rspN_valid for the owner only, for exactly one cycle; go to IDLE.
- Requester protocol:
  - Drops or changes req_valid in the cycle after rsp_valid.
  - A new request sampled in the following IDLE cycle is legal (back-to-back).
- Latency: zero-wait transfer gives rsp_valid 3 cycles after req_valid is first sampled in IDLE; each wait state adds 1 cycle.
- APB output drive:
  - APB outputs come from latched registers, not from requester inputs.
  - o_pstrb = 0 on reads.
  - o_paddr, o_pwdata, o_pwrite hold their values through all of SETUP and ACCESS.
- Arbitration:
  - PRIO_MODE=0: on simultaneous requests, grant the port not granted last. last_grant resets to 1, so port 0 wins the first tie.
  - A single requester always wins.
  - PRIO_MODE=1: port 0 always wins a tie.
  - Arbitration happens only in IDLE; a grant is never preempted.
- Stall: o_stallN is high for every cycle the port is pending, including while the other port owns the bus. It drops in the rsp_valid cycle.
- Reset values: all APB outputs 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, o_busy 0, o_owner 0, state IDLE, last_grant 1.
- Reset mid-transfer: asynchronous return to IDLE; psel/penable drop immediately; no response is issued.
- A requester dropping valid while owning the bus is a protocol violation. The transfer still completes, and rsp_valid still pulses.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on SETUP entry and increments each ACCESS cycle with i_pready=0.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err=1 and rdata=0; psel drops.
  - A late i_pready is ignored.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Port 0 read, addr 0x1000_0004, i_prdata=0xDEAD_BEEF, pready=1 on first ACCESS -> psel at +1, penable at +2, o_rsp0_valid at +3 with rdata 0xDEAD_BEEF, err 0; o_stall0 high at +0..+2 and low at +3.
- Port 1 write 0xA5A5_0001, strb 0xF, 3 wait states -> pwdata/paddr/pstrb stable for all 4 ACCESS cycles; o_rsp1_valid 6 cycles after request; rdata 0.
- Both ports request continuously, PRIO_MODE=0 -> grants alternate 0,1,0,1 and each port gets rsp_valid every second transfer; PRIO_MODE=1 -> port 0 only.
- pslverr=1 with pready=1 on a port 0 read -> o_rsp0_err=1 for one cycle, then IDLE; the next transfer reports err=0.
- i_reset asserted during ACCESS wait -> psel/penable/busy go 0 without a clock edge; no rsp_valid; a new request after release completes normally.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and pready held 0 -> rsp_valid with err=1 and rdata=0 after 4 ACCESS wait cycles; a pready pulse one cycle later is ignored.
